// File: rtl/estimador_mvmult_launcher.sv
// ap_ctrl_hs initiator for the estimator row matrix-vector kernel: launches one run per sample
// and returns the three captured row results as one beat. Optional hang detection: MVMULT_LAUNCHER_TIMEOUT_EN.
module estimador_mvmult_launcher #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x,
  output logic                     k_start,
  input  logic                     k_ready,
  input  logic                     k_done,
  input  logic                     k_idle,
  output logic signed [DATA_W-1:0] k_x,
  input  logic signed [DATA_W-1:0] k_y0,
  input  logic signed [DATA_W-1:0] k_y1,
  input  logic signed [DATA_W-1:0] k_y2,
  input  logic                     k_y0_vld,
  input  logic                     k_y1_vld,
  input  logic                     k_y2_vld,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_y0,
  output logic signed [DATA_W-1:0] out_y1,
  output logic signed [DATA_W-1:0] out_y2,
  output logic                     busy,
  output logic                     err,
  output logic [CNT_W-1:0]         run_count
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE_CHK, S_OUT} state_t;

  state_t                     state, state_nxt;
  logic [2:0]                 mask;
  logic [2:0]                 lane_vld;
  logic signed [DATA_W-1:0]   cap0, cap1, cap2;
  logic                       accept, cap_en, proto_err, miss, timeout;

  assign in_ready  = (state == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign lane_vld  = {k_y2_vld, k_y1_vld, k_y0_vld};
  // Results are legal while the run is in flight; LAUNCH counts since ap_ready and ap_done may coincide.
  assign cap_en    = (state == S_LAUNCH) || (state == S_WAIT);
  assign proto_err = !cap_en && ((|lane_vld) || k_done);
  assign miss      = (state == S_DONE_CHK) && (mask != 3'b111);

`ifdef MVMULT_LAUNCHER_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCNT_W-1:0] tcnt;

  function automatic logic signed [DATA_W-1:0] sat_min();
    return {1'b1, {(DATA_W-1){1'b0}}};
  endfunction

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)              tcnt <= '0;
    else if (state != S_WAIT)   tcnt <= '0;
    else                        tcnt <= tcnt + 1'b1;
  end

  logic unused_ok;
  assign unused_ok = k_idle;
`else
  logic unused_ok;
  assign unused_ok = ^{k_idle, 32'(TIMEOUT_CYCLES)};
`endif

  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      S_IDLE:     if (accept) state_nxt = S_LAUNCH;
      S_LAUNCH:   if (k_ready) state_nxt = k_done ? S_DONE_CHK : S_WAIT;
      S_WAIT: begin
        if (k_done) state_nxt = S_DONE_CHK;
`ifdef MVMULT_LAUNCHER_TIMEOUT_EN
        else if (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = S_OUT;
          timeout   = 1'b1;
        end
`endif
      end
      S_DONE_CHK: state_nxt = S_OUT;
      S_OUT:      if (out_ready) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= S_IDLE;
      k_start   <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      mask      <= '0;
      err       <= 1'b0;
      run_count <= '0;
      k_x       <= '0;
      out_y0    <= '0;
      out_y1    <= '0;
      out_y2    <= '0;
    end else begin
      state     <= state_nxt;
      k_start   <= (state_nxt == S_LAUNCH);
      busy      <= (state_nxt != S_IDLE);
      out_valid <= (state_nxt == S_OUT);
      if (accept) begin
        k_x  <= in_x;
        mask <= '0;
      end else if (cap_en) begin
        mask <= mask | lane_vld;
      end
      if (proto_err || miss || timeout) err <= 1'b1;
      if (state == S_DONE_CHK) begin
        out_y0    <= cap0;
        out_y1    <= cap1;
        out_y2    <= cap2;
        run_count <= run_count + 1'b1;
      end
`ifdef MVMULT_LAUNCHER_TIMEOUT_EN
      else if (timeout) begin
        out_y0 <= sat_min();
        out_y1 <= sat_min();
        out_y2 <= sat_min();
      end
`endif
    end
  end

  // Capture lanes are cleared per run, so reset is not needed on this datapath.
  always_ff @(posedge ap_clk) begin
    if (accept) begin
      cap0 <= '0;
      cap1 <= '0;
      cap2 <= '0;
    end else if (cap_en) begin
      if (k_y0_vld) cap0 <= k_y0;
      if (k_y1_vld) cap1 <= k_y1;
      if (k_y2_vld) cap2 <= k_y2;
    end
  end

endmodule

// File: tb/tb_estimador_mvmult_launcher.sv
// Directed bench for estimador_mvmult_launcher; timeout scenario runs when MVMULT_LAUNCHER_TIMEOUT_EN is defined.
module tb_estimador_mvmult_launcher;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
`ifdef MVMULT_LAUNCHER_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_x, k_x;
  logic              k_start, k_ready, k_done, k_idle;
  logic [DATA_W-1:0] k_y0, k_y1, k_y2;
  logic              k_y0_vld, k_y1_vld, k_y2_vld;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_y0, out_y1, out_y2;
  logic              busy, err;
  logic [CNT_W-1:0]  run_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 ap_clk = ~ap_clk;

  estimador_mvmult_launcher #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .k_start(k_start), .k_ready(k_ready), .k_done(k_done), .k_idle(k_idle), .k_x(k_x),
    .k_y0(k_y0), .k_y1(k_y1), .k_y2(k_y2),
    .k_y0_vld(k_y0_vld), .k_y1_vld(k_y1_vld), .k_y2_vld(k_y2_vld),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y0(out_y0), .out_y1(out_y1), .out_y2(out_y2),
    .busy(busy), .err(err), .run_count(run_count)
  );

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic accept_sample(input logic [DATA_W-1:0] x);
    in_valid = 1'b1;
    in_x     = x;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic kernel_ack();
    k_ready = 1'b1;
    tick();
    k_ready = 1'b0;
  endtask

  // Sends selected lanes on separate cycles, then ap_done, then lets DONE_CHK pass.
  task automatic kernel_results(input logic [2:0] lanes, input logic [DATA_W-1:0] y0,
                                input logic [DATA_W-1:0] y1, input logic [DATA_W-1:0] y2);
    if (lanes[0]) begin k_y0 = y0; k_y0_vld = 1'b1; tick(); k_y0_vld = 1'b0; end
    if (lanes[1]) begin k_y1 = y1; k_y1_vld = 1'b1; tick(); k_y1_vld = 1'b0; end
    if (lanes[2]) begin k_y2 = y2; k_y2_vld = 1'b1; tick(); k_y2_vld = 1'b0; end
    k_done = 1'b1;
    tick();
    k_done = 1'b0;
    tick();
  endtask

  task automatic release_beat();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    tick();
    vectors++;
    if ({k_start, busy, out_valid, err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got start/busy/oval/err=%b want 0000", {k_start, busy, out_valid, err});
    end
    vectors++;
    if ({k_x, out_y0, out_y1, out_y2, run_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got kx=%h y=%h/%h/%h cnt=%0d want all 0", k_x, out_y0, out_y1, out_y2, run_count);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    ap_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    accept_sample(32'h0001_0000);
    vectors++;
    if ({k_start, busy, in_ready} !== 3'b110 || k_x !== 32'h0001_0000) begin
      miscompares++;
      $display("FAIL nominal_launch: got start/busy/in_ready=%b kx=%h want 110 00010000", {k_start, busy, in_ready}, k_x);
    end
    kernel_ack();
    vectors++;
    if (k_start !== 1'b0) begin
      miscompares++;
      $display("FAIL nominal_start_drop: got %b want 0", k_start);
    end
    kernel_results(3'b111, 32'd44818, 32'd491, 32'd0);
    vectors++;
    if (out_valid !== 1'b1 || out_y0 !== 32'h0000_AF12 || out_y1 !== 32'h0000_01EB || out_y2 !== 32'h0) begin
      miscompares++;
      $display("FAIL nominal_beat: got v=%b y=%h/%h/%h want 1 0000af12/000001eb/00000000", out_valid, out_y0, out_y1, out_y2);
    end
    vectors++;
    if (err !== 1'b0 || run_count !== 16'd1) begin
      miscompares++;
      $display("FAIL nominal_status: got err=%b cnt=%0d want 0 1", err, run_count);
    end
    release_beat();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL nominal_release: got oval=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    accept_sample(32'h0002_0000);
    kernel_ack();
    kernel_results(3'b111, 32'hFFFF_FFFF, 32'h0000_0007, 32'h8000_0001);
    // Upstream keeps offering a sample; it must not be taken while the beat is pending.
    in_valid = 1'b1;
    in_x     = 32'h0BAD_0000;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_y0 !== 32'hFFFF_FFFF || out_y1 !== 32'h7 || out_y2 !== 32'h8000_0001
          || in_ready !== 1'b0 || k_start !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure_hold[%0d]: got v=%b y=%h/%h/%h in_ready=%b start=%b want 1 ffffffff/00000007/80000001 0 0",
                 i, out_valid, out_y0, out_y1, out_y2, in_ready, k_start);
      end
      tick();
    end
    in_valid = 1'b0;
    release_beat();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || k_start !== 1'b0 || run_count !== 16'd2) begin
      miscompares++;
      $display("FAIL backpressure_release: got oval=%b in_ready=%b start=%b cnt=%0d want 0 1 0 2",
               out_valid, in_ready, k_start, run_count);
    end
  endtask

  task automatic test_delayed_ready();
    accept_sample(32'hFFFE_8000);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (k_start !== 1'b1 || k_x !== 32'hFFFE_8000) begin
        miscompares++;
        $display("FAIL delayed_ready_hold[%0d]: got start=%b kx=%h want 1 fffe8000", i, k_start, k_x);
      end
      tick();
    end
    kernel_ack();
    vectors++;
    if (k_start !== 1'b0 || k_x !== 32'hFFFE_8000) begin
      miscompares++;
      $display("FAIL delayed_ready_drop: got start=%b kx=%h want 0 fffe8000", k_start, k_x);
    end
    kernel_results(3'b111, 32'h1, 32'h2, 32'h3);
    release_beat();
  endtask

  task automatic test_missing_lane();
    accept_sample(32'h0003_0000);
    kernel_ack();
    kernel_results(3'b101, 32'h0000_1111, 32'h0000_2222, 32'h0000_3333);
    vectors++;
    if (out_valid !== 1'b1 || out_y0 !== 32'h1111 || out_y1 !== 32'h0 || out_y2 !== 32'h3333 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL missing_lane_beat: got v=%b y=%h/%h/%h err=%b want 1 00001111/00000000/00003333 1",
               out_valid, out_y0, out_y1, out_y2, err);
    end
    release_beat();
    // Clean follow-up run: repeated y0 strobe (last wins) and y2 coincident with ap_done.
    accept_sample(32'h0004_0000);
    kernel_ack();
    k_y0 = 32'h0000_00AA; k_y0_vld = 1'b1; tick();
    k_y0 = 32'h0000_00BB; tick(); k_y0_vld = 1'b0;
    k_y1 = 32'h0000_00CC; k_y1_vld = 1'b1; tick(); k_y1_vld = 1'b0;
    k_y2 = 32'h0000_00DD; k_y2_vld = 1'b1; k_done = 1'b1; tick();
    k_y2_vld = 1'b0; k_done = 1'b0;
    tick();
    vectors++;
    if (out_y0 !== 32'hBB || out_y1 !== 32'hCC || out_y2 !== 32'hDD || err !== 1'b1 || run_count !== 16'd5) begin
      miscompares++;
      $display("FAIL sticky_err_clean_run: got y=%h/%h/%h err=%b cnt=%0d want 000000bb/000000cc/000000dd 1 5",
               out_y0, out_y1, out_y2, err, run_count);
    end
    release_beat();
  endtask

  task automatic test_reset_mid_run();
    accept_sample(32'h0005_0000);
    kernel_ack();
    k_y0 = 32'h55; k_y0_vld = 1'b1; tick(); k_y0_vld = 1'b0;
    ap_rst_n = 1'b0;
    #1;
    vectors++;
    if ({k_start, busy, out_valid, err} !== 4'b0000 || k_x !== '0 || run_count !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_run: got start/busy/oval/err=%b kx=%h cnt=%0d want 0000 0 0",
               {k_start, busy, out_valid, err}, k_x, run_count);
    end
    tick();
    ap_rst_n = 1'b1;
    tick();
    accept_sample(32'h0006_0000);
    kernel_ack();
    kernel_results(3'b111, 32'h10, 32'h20, 32'h30);
    vectors++;
    if (out_valid !== 1'b1 || out_y0 !== 32'h10 || out_y1 !== 32'h20 || out_y2 !== 32'h30
        || err !== 1'b0 || run_count !== 16'd1) begin
      miscompares++;
      $display("FAIL post_reset_run: got v=%b y=%h/%h/%h err=%b cnt=%0d want 1 10/20/30 0 1",
               out_valid, out_y0, out_y1, out_y2, err, run_count);
    end
    release_beat();
  endtask

  task automatic test_stray_done();
    k_done = 1'b1;
    tick();
    k_done = 1'b0;
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stray_done_idle: got err=%b busy=%b oval=%b want 1 0 0", err, busy, out_valid);
    end
  endtask

`ifdef MVMULT_LAUNCHER_TIMEOUT_EN
  task automatic test_timeout();
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    tick();
    accept_sample(32'h0007_0000);
    kernel_ack();
    for (int i = 0; i < TMO - 1; i++) tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: got oval=%b want 0", out_valid);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_y0 !== 32'h8000_0000 || out_y1 !== 32'h8000_0000 || out_y2 !== 32'h8000_0000
        || err !== 1'b1 || run_count !== 16'd0) begin
      miscompares++;
      $display("FAIL timeout_beat: got v=%b y=%h/%h/%h err=%b cnt=%0d want 1 80000000 x3 1 0",
               out_valid, out_y0, out_y1, out_y2, err, run_count);
    end
    release_beat();
  endtask
`endif

  initial begin
    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    k_ready   = 1'b0;
    k_done    = 1'b0;
    k_idle    = 1'b0;
    k_y0      = '0;
    k_y1      = '0;
    k_y2      = '0;
    k_y0_vld  = 1'b0;
    k_y1_vld  = 1'b0;
    k_y2_vld  = 1'b0;
    out_ready = 1'b0;
    #2;
    test_reset();
    test_nominal();
    test_backpressure();
    test_delayed_ready();
    test_missing_lane();
    test_reset_mid_run();
    test_stray_done();
`ifdef MVMULT_LAUNCHER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/estimador_mvmult_launcher.md
Name: estimador_mvmult_launcher

Overview:
- Initiator side of the ap_ctrl_hs handshake for the estimator's row matrix-vector kernel.
- Accepts one Q16.16 input sample from upstream via valid/ready, drives the kernel's ap_start and holds its scalar input stable for the whole run.
- Captures the three ap_vld-qualified row results, then presents them as one atomic result beat downstream via valid/ready.
- Sits between the estimator sample sequencer and the state-update datapath.

Parameters:
- DATA_W, 32, width of the input scalar and of each result lane (Q16.16).
- TIMEOUT_CYCLES, 64, maximum number of WAIT cycles before the kernel is declared hung. Used only with the optional feature.
- CNT_W, 16, width of the completed-run counter.

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream sample valid
- in_ready  out  1  launcher can accept a sample
- in_x  in  DATA_W  upstream sample, Q16.16 signed
- k_start  out  1  kernel ap_start
- k_ready  in  1  kernel ap_ready
- k_done  in  1  kernel ap_done
- k_idle  in  1  kernel ap_idle
- k_x  out  DATA_W  kernel scalar input, registered
- k_y0, k_y1, k_y2  in  DATA_W each  kernel result lanes
- k_y0_vld, k_y1_vld, k_y2_vld  in  1 each  lane valid strobes
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts
- out_y0, out_y1, out_y2  out  DATA_W each  captured results
- busy  out  1  FSM not in IDLE
- err  out  1  sticky protocol/timeout error
- run_count  out  CNT_W  number of completed runs, wraps modulo 2^CNT_W

Behaviour:
- Reset is asynchronous on ap_rst_n low. All outputs are 0, FSM goes to IDLE, the capture mask clears, and err clears.
- All outputs are registered except in_ready, which is asserted exactly when the FSM is in IDLE.
- IDLE
  - On in_valid&in_ready: register in_x into k_x, clear the capture mask and capture registers, go to LAUNCH.
- LAUNCH
  - k_start=1.
  - On k_ready=1: drop k_start the next cycle and go to WAIT.
  - If k_done=1 in the same cycle as k_ready, go straight to DONE_CHK.
  - k_start stays high until k_ready is seen, per ap_ctrl_hs.
- WAIT
  - k_start=0.
  - Any k_yN_vld high: latch k_yN into its capture register and set mask bit N. Strobes may arrive in the same or different cycles.
  - A repeated strobe overwrites the register (last value wins).
  - On k_done=1: go to DONE_CHK. Strobes coincident with k_done are captured.
- DONE_CHK (1 cycle)
  - If mask != 3'b111: set err; lanes not captured stay 0.
  - Load out_y0..2 from the capture registers, set out_valid, increment run_count (wraps), go to OUT.
- OUT
  - out_valid held and out_y* stable until out_ready=1.
  - On the accepting cycle go to IDLE, out_valid=0 the next cycle.
  - in_ready rises the cycle after acceptance, so there is no same-cycle bypass.
- Strobes or k_done outside WAIT/LAUNCH set err and are otherwise ignored.
- k_idle is informational only. k_idle=0 while in IDLE does not block launch.
- err is sticky and clears only on reset.
- Latency: from the in_valid accept cycle to out_valid is kernel latency + 2 cycles (1 into LAUNCH, 1 for DONE_CHK).

Optional Feature:
- MVMULT_LAUNCHER_TIMEOUT_EN defined:
  - A counter runs while in WAIT.
  - On reaching TIMEOUT_CYCLES without k_done: set err, force all out_y* to 32'h8000_0000 (the saturation minimum, as a marker), go to OUT.
  - run_count is not incremented in this case.
- Not defined: no counter; WAIT waits indefinitely for k_done.

Test Plan:
- Nominal run: in_x=32'h0001_0000; kernel model returns y0=44818, y1=491, y2=0 on separate cycles, then k_done -> one out beat {0x0000AF12, 0x000001EB, 0x00000000}, err=0, run_count=1.
- Backpressure: out_ready held low for 10 cycles after out_valid -> out_valid and out_y* stable throughout, in_ready=0, no second k_start. Release -> in_ready=1 the next cycle.
- Delayed ap_ready: k_ready held low for 5 cycles after k_start -> k_start stays high all 5 cycles, drops the cycle after k_ready, k_x unchanged.
- Missing lane: model omits k_y1_vld -> out beat {y0, 0, y2}, err=1 and stays 1 across the next clean run.
- Reset mid-run: assert ap_rst_n low in WAIT -> outputs 0, k_start=0, busy=0 immediately. After release, a fresh run completes normally with run_count=1.
- Timeout (macro on, TIMEOUT_CYCLES=8): kernel never asserts k_done -> after 8 WAIT cycles out beat of three 0x80000000 values, err=1, run_count unchanged.
